// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-requester arbiter and sequencer for the shared memory port
//   (MAR / memory / MDR path). IF (instruction fetch, read-only) and EX
//   (load/store, read/write) compete for the port. One access is run at a
//   time as IDLE -> ADDR -> ACCESS (wait on MFC or time out) -> DONE.
//   Contention is resolved round-robin.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   if_req/if_addr      fetch read request; held until if_ack
//   if_ack/if_err       one-cycle completion pulse to IF; timeout flag
//   ex_req/ex_we/       execute request; we = 1 means write
//   ex_addr/ex_wdata
//   ex_ack/ex_err       one-cycle completion pulse to EX; timeout flag
//   rdata               captured read data; valid while either ack is high
//   mem_addr/mem_wdata  latched address and write data to memory
//   mem_rdata           memory data in; sampled on the ACCESS->DONE edge
//   mem_EN/mem_RW       memory enable; 1 = read, 0 = write
//   MFC                 memory function complete
//   grant               01 = IF owns port, 10 = EX owns port, 00 = idle
//   busy                high in every state except IDLE
module mem_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic              if_err,
  input  logic              ex_req,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              ex_ack,
  output logic              ex_err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_EN,
  output logic              mem_RW,
  input  logic              MFC,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LP_CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam bit LP_TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_owner_ex;  // 1 = EX owns the current transaction
  logic              r_last_ex;   // 1 = EX was granted most recently
  logic              r_we;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [CNT_W-1:0]  r_cnt;

  logic w_start;
  logic w_pick_ex;
  logic w_mfc_done;
  logic w_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_pick_ex  = 1'b0;
    w_mfc_done = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (if_req || ex_req) begin
          w_start = 1'b1;
          // EX wins when alone, or on contention when IF was granted last
          w_pick_ex = ex_req && (!if_req || !r_last_ex);
          w_next = S_ADDR;
        end
      end
      S_ADDR: w_next = S_ACCESS;
      S_ACCESS: begin
        // MFC takes priority over a timeout on the same edge
        if (MFC) begin
          w_mfc_done = 1'b1;
          w_next = S_DONE;
        end else if (LP_TO_EN && (r_cnt == LP_CNT_LAST)) begin
          w_timeout = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner_ex <= 1'b0;
      r_last_ex  <= 1'b1;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_start) begin
        r_owner_ex <= w_pick_ex;
        r_last_ex  <= w_pick_ex;
        r_addr     <= w_pick_ex ? ex_addr : if_addr;
        r_we       <= w_pick_ex & ex_we;
        r_wdata    <= w_pick_ex ? ex_wdata : '0;
        r_err      <= 1'b0;
        r_rdata    <= '0;
      end
      if (w_mfc_done) begin
        r_rdata <= r_we ? '0 : mem_rdata;
        r_err   <= 1'b0;
      end
      if (w_timeout) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
      r_cnt <= (r_state == S_ACCESS) ? r_cnt + CNT_W'(1) : '0;
    end
  end

  always_comb begin
    grant  = 2'b00;
    busy   = 1'b0;
    mem_EN = 1'b0;
    mem_RW = 1'b0;
    if_ack = 1'b0;
    ex_ack = 1'b0;
    if (r_state != S_IDLE) begin
      grant = r_owner_ex ? 2'b10 : 2'b01;
      busy  = 1'b1;
    end
    if (r_state == S_ADDR || r_state == S_ACCESS) mem_RW = ~r_we;
    if (r_state == S_ACCESS) mem_EN = 1'b1;
    if (r_state == S_DONE) begin
      if_ack = ~r_owner_ex;
      ex_ack = r_owner_ex;
    end
  end

  assign if_err    = if_ack & r_err;
  assign ex_err    = ex_ack & r_err;
  assign rdata     = r_rdata;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_ack;
  logic        if_err;
  logic        ex_req;
  logic        ex_we;
  logic [7:0]  ex_addr;
  logic [15:0] ex_wdata;
  logic        ex_ack;
  logic        ex_err;
  logic [15:0] rdata;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_EN;
  logic        mem_RW;
  logic        MFC;
  logic [1:0]  grant;
  logic        busy;

  int n_pass;
  int n_total;

  mem_port_arbiter #(
    .ADDR_W (8),
    .DATA_W (16),
    .TIMEOUT(15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_err   (if_err),
    .ex_req   (ex_req),
    .ex_we    (ex_we),
    .ex_addr  (ex_addr),
    .ex_wdata (ex_wdata),
    .ex_ack   (ex_ack),
    .ex_err   (ex_err),
    .rdata    (rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_EN   (mem_EN),
    .mem_RW   (mem_RW),
    .MFC      (MFC),
    .grant    (grant),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_en"}, 32'(mem_EN), 32'h0);
    chk({tag, "_acks"}, 32'({if_ack, ex_ack}), 32'h0);
  endtask

  initial begin
    int cnt;
    n_pass = 0;
    n_total = 0;
    rst = 1'b0;
    if_req = 1'b0;
    if_addr = '0;
    ex_req = 1'b0;
    ex_we = 1'b0;
    ex_addr = '0;
    ex_wdata = '0;
    mem_rdata = '0;
    MFC = 1'b0;
    #2 rst = 1'b1;
    step();

    // reset state
    chk_idle_outputs("rst");
    chk("rst_rw", 32'(mem_RW), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_errs", 32'({if_err, ex_err}), 32'h0);
    step();
    rst = 1'b0;
    step();

    // IF read 0x10, MFC high in first ACCESS cycle
    if_req = 1'b1;
    if_addr = 8'h10;
    mem_rdata = 16'hBEEF;
    MFC = 1'b1;
    step();
    chk("t1_addr_grant", 32'(grant), 32'h1);
    chk("t1_addr_en", 32'(mem_EN), 32'h0);
    chk("t1_addr_rw", 32'(mem_RW), 32'h1);
    chk("t1_addr_maddr", 32'(mem_addr), 32'h10);
    step();
    chk("t1_acc_en", 32'(mem_EN), 32'h1);
    chk("t1_acc_rw", 32'(mem_RW), 32'h1);
    chk("t1_acc_ack", 32'(if_ack), 32'h0);
    step();
    chk("t1_done_ack", 32'(if_ack), 32'h1);
    chk("t1_done_exack", 32'(ex_ack), 32'h0);
    chk("t1_done_err", 32'(if_err), 32'h0);
    chk("t1_done_rdata", 32'(rdata), 32'hBEEF);
    chk("t1_done_en", 32'(mem_EN), 32'h0);
    chk("t1_done_grant", 32'(grant), 32'h1);
    if_req = 1'b0;
    MFC = 1'b0;
    step();
    chk_idle_outputs("t1_idle");

    // EX write 0x22 <- 0x1234, MFC after 4 low ACCESS cycles
    ex_req = 1'b1;
    ex_we = 1'b1;
    ex_addr = 8'h22;
    ex_wdata = 16'h1234;
    mem_rdata = 16'hAAAA;
    step();
    chk("t2_addr_grant", 32'(grant), 32'h2);
    chk("t2_addr_rw", 32'(mem_RW), 32'h0);
    chk("t2_addr_en", 32'(mem_EN), 32'h0);
    chk("t2_addr_maddr", 32'(mem_addr), 32'h22);
    chk("t2_addr_mwdata", 32'(mem_wdata), 32'h1234);
    ex_addr = 8'hEE;
    ex_wdata = 16'hDEAD;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_acc_en", 32'(mem_EN), 32'h1);
      chk("t2_acc_rw", 32'(mem_RW), 32'h0);
      chk("t2_acc_maddr", 32'(mem_addr), 32'h22);
      chk("t2_acc_mwdata", 32'(mem_wdata), 32'h1234);
      chk("t2_acc_ack", 32'(ex_ack), 32'h0);
      if (i == 4) MFC = 1'b1;
    end
    step();
    chk("t2_done_ack", 32'(ex_ack), 32'h1);
    chk("t2_done_ifack", 32'(if_ack), 32'h0);
    chk("t2_done_err", 32'(ex_err), 32'h0);
    chk("t2_done_rdata", 32'(rdata), 32'h0);
    chk("t2_done_en", 32'(mem_EN), 32'h0);
    ex_req = 1'b0;
    MFC = 1'b0;
    step();
    chk_idle_outputs("t2_idle");

    // both requesters held through 4 transactions after reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    if_req = 1'b1;
    if_addr = 8'h44;
    ex_req = 1'b1;
    ex_we = 1'b0;
    ex_addr = 8'h33;
    mem_rdata = 16'h5A5A;
    MFC = 1'b1;
    step();
    for (int t = 0; t < 4; t++) begin
      logic exp_ex;
      exp_ex = (t % 2) == 1;
      chk("t3_grant", 32'(grant), exp_ex ? 32'h2 : 32'h1);
      chk("t3_maddr", 32'(mem_addr), exp_ex ? 32'h33 : 32'h44);
      step();
      chk("t3_acc_acks", 32'({if_ack, ex_ack}), 32'h0);
      step();
      chk("t3_done_acks", 32'({if_ack, ex_ack}), exp_ex ? 32'h1 : 32'h2);
      chk("t3_done_rdata", 32'(rdata), 32'h5A5A);
      if (t == 3) begin
        if_req = 1'b0;
        ex_req = 1'b0;
      end
      step();
      chk_idle_outputs("t3_idle");
      if (t != 3) step();
    end
    MFC = 1'b0;

    // EX read, no MFC: times out after 15 ACCESS cycles
    ex_req = 1'b1;
    ex_we = 1'b0;
    ex_addr = 8'h55;
    mem_rdata = 16'h7777;
    step();
    chk("t4_addr_grant", 32'(grant), 32'h2);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!mem_EN) break;
      cnt++;
    end
    chk("t4_access_cycles", 32'(cnt), 32'd15);
    chk("t4_done_ack", 32'(ex_ack), 32'h1);
    chk("t4_done_err", 32'(ex_err), 32'h1);
    chk("t4_done_rdata", 32'(rdata), 32'h0);
    ex_req = 1'b0;
    step();
    chk_idle_outputs("t4_idle");
    if_req = 1'b1;
    if_addr = 8'h66;
    mem_rdata = 16'h1357;
    MFC = 1'b1;
    step();
    chk("t4_if_grant", 32'(grant), 32'h1);
    step();
    step();
    chk("t4_if_ack", 32'(if_ack), 32'h1);
    chk("t4_if_err", 32'(if_err), 32'h0);
    chk("t4_if_rdata", 32'(rdata), 32'h1357);
    if_req = 1'b0;
    MFC = 1'b0;
    step();

    // MFC on the same edge as the timeout count
    ex_req = 1'b1;
    ex_we = 1'b0;
    ex_addr = 8'h77;
    mem_rdata = 16'h2468;
    step();
    for (int i = 0; i < 15; i++) step();
    chk("t5_last_acc_en", 32'(mem_EN), 32'h1);
    MFC = 1'b1;
    step();
    chk("t5_done_ack", 32'(ex_ack), 32'h1);
    chk("t5_done_err", 32'(ex_err), 32'h0);
    chk("t5_done_rdata", 32'(rdata), 32'h2468);
    ex_req = 1'b0;
    MFC = 1'b0;
    step();

    // MFC pulse in IDLE is ignored
    MFC = 1'b1;
    step();
    chk_idle_outputs("t5_mfc_idle");
    MFC = 1'b0;
    step();
    chk_idle_outputs("t5_mfc_idle2");

    // asynchronous reset mid-ACCESS of an IF read
    if_req = 1'b1;
    if_addr = 8'h88;
    step();
    step();
    chk("t6_acc_en", 32'(mem_EN), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_en", 32'(mem_EN), 32'h0);
    chk("t6_async_grant", 32'(grant), 32'h0);
    chk("t6_async_busy", 32'(busy), 32'h0);
    chk("t6_async_maddr", 32'(mem_addr), 32'h0);
    chk("t6_async_rw", 32'(mem_RW), 32'h0);
    step();
    chk("t6_rst_noack", 32'(if_ack), 32'h0);
    step();
    chk("t6_rst_noack2", 32'(if_ack), 32'h0);
    ex_req = 1'b1;
    ex_addr = 8'h99;
    rst = 1'b0;
    step();
    chk("t6_post_grant", 32'(grant), 32'h1);
    chk("t6_post_maddr", 32'(mem_addr), 32'h88);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
